// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB master bridging a simple request port onto an APB bus.
// SETUP/ACCESS sequencing with back-to-back chaining and a wait-state timeout.
module apb_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int PSEL_WIDTH   = 1,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                  PCLK_i,
    input  logic                  PRESET_i,
    input  logic [1:0]            PMODE_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_i,
    input  logic [PSEL_WIDTH-1:0] PSEL_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_i,
    input  logic                  PREADY_i,
    input  logic [DATA_WIDTH-1:0] PRDATA_i,
    output logic                  PWRITE_o,
    output logic [ADDR_WIDTH-1:0] PADDR_o,
    output logic [PSEL_WIDTH-1:0] PSEL_o,
    output logic                  PENABLE_o,
    output logic [DATA_WIDTH-1:0] PWDATA_o,
    output logic                  PREADY_o,
    output logic [DATA_WIDTH-1:0] PRDATA_o,
    output logic                  PSLVERR_o
);
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [PSEL_WIDTH-1:0] r_psel;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pslverr;

    logic w_req_valid;
    logic w_done;
    logic w_timeout;
    logic w_capture;

    assign w_req_valid = PMODE_i[1] && (|PSEL_i);
    assign w_done      = (r_state == ACCESS) && PREADY_i;
    assign w_timeout   = (r_state == ACCESS) && !PREADY_i &&
                         (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
    // A new request is only accepted from IDLE or on the completing ACCESS edge.
    assign w_capture   = w_req_valid && ((r_state == IDLE) || w_done);

    always_ff @(posedge PCLK_i or negedge PRESET_i) begin
        if (!PRESET_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req_valid) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS: begin
                if (PREADY_i)       w_next = w_req_valid ? SETUP : IDLE;
                else if (w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK_i or negedge PRESET_i) begin
        if (!PRESET_i) begin
            r_wait_cnt <= '0;
            r_paddr    <= '0;
            r_psel     <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
        end else begin
            if ((r_state == ACCESS) && !PREADY_i && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            r_pslverr <= w_timeout;
            if (w_done && !r_pwrite) begin
                r_prdata <= PRDATA_i;
            end
            if (w_capture) begin
                r_paddr  <= PADDR_i;
                r_psel   <= PSEL_i;
                r_pwrite <= PMODE_i[0];
                if (PMODE_i[0]) begin
                    r_pwdata <= PWDATA_i;
                end
            end
        end
    end

    // Select is gated in IDLE so a timeout abort drops it without clearing r_psel.
    assign PSEL_o    = (r_state != IDLE) ? r_psel : '0;
    assign PENABLE_o = (r_state == ACCESS);
    assign PREADY_o  = w_done;
    assign PADDR_o   = r_paddr;
    assign PWRITE_o  = r_pwrite;
    assign PWDATA_o  = r_pwdata;
    assign PRDATA_o  = r_prdata;
    assign PSLVERR_o = r_pslverr;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - Table-driven and sequence checks for apb_master.
module tb_apb_master;
    logic       PCLK_i;
    logic       PRESET_i;
    logic [1:0] PMODE_i;
    logic [7:0] PADDR_i;
    logic [0:0] PSEL_i;
    logic [7:0] PWDATA_i;
    logic       PREADY_i;
    logic [7:0] PRDATA_i;
    logic       PWRITE_o;
    logic [7:0] PADDR_o;
    logic [0:0] PSEL_o;
    logic       PENABLE_o;
    logic [7:0] PWDATA_o;
    logic       PREADY_o;
    logic [7:0] PRDATA_o;
    logic       PSLVERR_o;

    apb_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .PSEL_WIDTH(1), .WAIT_TIMEOUT(16)
    ) dut (
        .PCLK_i(PCLK_i), .PRESET_i(PRESET_i), .PMODE_i(PMODE_i),
        .PADDR_i(PADDR_i), .PSEL_i(PSEL_i), .PWDATA_i(PWDATA_i),
        .PREADY_i(PREADY_i), .PRDATA_i(PRDATA_i), .PWRITE_o(PWRITE_o),
        .PADDR_o(PADDR_o), .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
        .PWDATA_o(PWDATA_o), .PREADY_o(PREADY_o), .PRDATA_o(PRDATA_o),
        .PSLVERR_o(PSLVERR_o)
    );

    initial PCLK_i = 1'b0;
    always #5 PCLK_i = ~PCLK_i;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] addr;
        logic       sel;
        logic [7:0] wdata;
        logic       rdy;
        logic [7:0] rdata;
        logic       e_pwrite;
        logic [7:0] e_paddr;
        logic       e_psel;
        logic       e_pen;
        logic [7:0] e_pwdata;
        logic       e_prdy;
        logic [7:0] e_prdata;
        logic       e_err;
    } vec_t;

    vec_t vecs[15];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " PWRITE_o"},  32'(PWRITE_o),  32'h0);
        chk({tag, " PADDR_o"},   32'(PADDR_o),   32'h0);
        chk({tag, " PSEL_o"},    32'(PSEL_o),    32'h0);
        chk({tag, " PENABLE_o"}, 32'(PENABLE_o), 32'h0);
        chk({tag, " PWDATA_o"},  32'(PWDATA_o),  32'h0);
        chk({tag, " PREADY_o"},  32'(PREADY_o),  32'h0);
        chk({tag, " PRDATA_o"},  32'(PRDATA_o),  32'h0);
        chk({tag, " PSLVERR_o"}, 32'(PSLVERR_o), 32'h0);
    endtask

    task automatic drive(input logic [1:0] mode, input logic [7:0] addr, input logic sel,
                         input logic [7:0] wdata, input logic rdy, input logic [7:0] rdata);
        PMODE_i  = mode;
        PADDR_i  = addr;
        PSEL_i   = sel;
        PWDATA_i = wdata;
        PREADY_i = rdy;
        PRDATA_i = rdata;
    endtask

    initial begin
        int  en_cycles;
        bit  seen_rdy;
        bit  left_access;
        string tag;

        //          mode   addr   sel wdata  rdy rdata | pwr paddr  psel pen pwdata prdy prdata err
        vecs[0]  = '{2'b11, 8'h15, 1, 8'h28, 1, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0};
        vecs[1]  = '{2'b11, 8'h01, 1, 8'h72, 1, 8'h00,  1, 8'h15, 1, 0, 8'h28, 0, 8'h00, 0};
        vecs[2]  = '{2'b11, 8'h01, 1, 8'h72, 1, 8'h00,  1, 8'h15, 1, 1, 8'h28, 1, 8'h00, 0};
        vecs[3]  = '{2'b10, 8'h20, 1, 8'h99, 1, 8'hA5,  1, 8'h01, 1, 0, 8'h72, 0, 8'h00, 0};
        vecs[4]  = '{2'b10, 8'h20, 1, 8'h99, 1, 8'hA5,  1, 8'h01, 1, 1, 8'h72, 1, 8'h00, 0};
        vecs[5]  = '{2'b00, 8'h00, 1, 8'h00, 1, 8'hA5,  0, 8'h20, 1, 0, 8'h72, 0, 8'h00, 0};
        vecs[6]  = '{2'b00, 8'h00, 1, 8'h00, 1, 8'hA5,  0, 8'h20, 1, 1, 8'h72, 1, 8'h00, 0};
        vecs[7]  = '{2'b11, 8'h02, 1, 8'h66, 0, 8'h3C,  0, 8'h20, 0, 0, 8'h72, 0, 8'hA5, 0};
        vecs[8]  = '{2'b01, 8'h00, 1, 8'h00, 0, 8'h3C,  1, 8'h02, 1, 0, 8'h66, 0, 8'hA5, 0};
        vecs[9]  = '{2'b11, 8'h33, 1, 8'h11, 0, 8'h3C,  1, 8'h02, 1, 1, 8'h66, 0, 8'hA5, 0};
        vecs[10] = '{2'b11, 8'h33, 1, 8'h11, 0, 8'h3C,  1, 8'h02, 1, 1, 8'h66, 0, 8'hA5, 0};
        vecs[11] = '{2'b11, 8'h33, 1, 8'h11, 0, 8'h3C,  1, 8'h02, 1, 1, 8'h66, 0, 8'hA5, 0};
        vecs[12] = '{2'b00, 8'h00, 1, 8'h00, 1, 8'h3C,  1, 8'h02, 1, 1, 8'h66, 1, 8'hA5, 0};
        vecs[13] = '{2'b01, 8'h44, 1, 8'h00, 1, 8'h00,  1, 8'h02, 0, 0, 8'h66, 0, 8'hA5, 0};
        vecs[14] = '{2'b11, 8'h55, 0, 8'h00, 1, 8'h00,  1, 8'h02, 0, 0, 8'h66, 0, 8'hA5, 0};

        PRESET_i = 1'b0;
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00);
        #12;
        chk_all_zero("reset");
        @(negedge PCLK_i);
        PRESET_i = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge PCLK_i);
            drive(vecs[i].mode, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].rdy, vecs[i].rdata);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " PWRITE_o"},  32'(PWRITE_o),  32'(vecs[i].e_pwrite));
            chk({tag, " PADDR_o"},   32'(PADDR_o),   32'(vecs[i].e_paddr));
            chk({tag, " PSEL_o"},    32'(PSEL_o),    32'(vecs[i].e_psel));
            chk({tag, " PENABLE_o"}, 32'(PENABLE_o), 32'(vecs[i].e_pen));
            chk({tag, " PWDATA_o"},  32'(PWDATA_o),  32'(vecs[i].e_pwdata));
            chk({tag, " PREADY_o"},  32'(PREADY_o),  32'(vecs[i].e_prdy));
            chk({tag, " PRDATA_o"},  32'(PRDATA_o),  32'(vecs[i].e_prdata));
            chk({tag, " PSLVERR_o"}, 32'(PSLVERR_o), 32'(vecs[i].e_err));
        end

        // Timeout: read with PREADY_i stuck low.
        @(negedge PCLK_i);
        drive(2'b10, 8'h7E, 1'b1, 8'h00, 1'b0, 8'h5B);
        @(negedge PCLK_i);
        drive(2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h5B);
        #1;
        chk("to setup PSEL_o",    32'(PSEL_o),    32'h1);
        chk("to setup PENABLE_o", 32'(PENABLE_o), 32'h0);
        chk("to setup PADDR_o",   32'(PADDR_o),   32'h7E);
        chk("to setup PWRITE_o",  32'(PWRITE_o),  32'h0);
        en_cycles   = 0;
        seen_rdy    = 1'b0;
        left_access = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge PCLK_i);
            #1;
            if (PREADY_o) seen_rdy = 1'b1;
            if (PENABLE_o) begin
                en_cycles++;
            end else begin
                left_access = 1'b1;
                break;
            end
        end
        chk("to left ACCESS",       32'(left_access), 32'h1);
        chk("to ACCESS cycles",     32'(en_cycles),   32'd16);
        chk("to no PREADY_o",       32'(seen_rdy),    32'h0);
        chk("to idle PSEL_o",       32'(PSEL_o),      32'h0);
        chk("to PSLVERR_o pulse",   32'(PSLVERR_o),   32'h1);
        chk("to PRDATA_o held",     32'(PRDATA_o),    32'hA5);
        @(negedge PCLK_i);
        #1;
        chk("to PSLVERR_o cleared", 32'(PSLVERR_o),   32'h0);
        chk("to stays idle",        32'(PENABLE_o),   32'h0);

        // Reset asserted in ACCESS, then a fresh transfer from IDLE.
        @(negedge PCLK_i);
        drive(2'b11, 8'h3C, 1'b1, 8'h5A, 1'b0, 8'h00);
        @(negedge PCLK_i);
        drive(2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        @(negedge PCLK_i);
        #1;
        chk("rst pre ACCESS PENABLE_o", 32'(PENABLE_o), 32'h1);
        PREADY_i = 1'b1;
        #1;
        PRESET_i = 1'b0;
        #1;
        chk_all_zero("rst mid");
        @(negedge PCLK_i);
        #1;
        chk_all_zero("rst held");
        PRESET_i = 1'b1;
        @(negedge PCLK_i);
        drive(2'b11, 8'h09, 1'b1, 8'h77, 1'b1, 8'h00);
        #1;
        chk("post idle PSEL_o",    32'(PSEL_o),    32'h0);
        chk("post idle PREADY_o",  32'(PREADY_o),  32'h0);
        @(negedge PCLK_i);
        drive(2'b00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
        #1;
        chk("post setup PSEL_o",    32'(PSEL_o),    32'h1);
        chk("post setup PENABLE_o", 32'(PENABLE_o), 32'h0);
        chk("post setup PADDR_o",   32'(PADDR_o),   32'h09);
        chk("post setup PWDATA_o",  32'(PWDATA_o),  32'h77);
        @(negedge PCLK_i);
        #1;
        chk("post access PENABLE_o", 32'(PENABLE_o), 32'h1);
        chk("post access PREADY_o",  32'(PREADY_o),  32'h1);
        @(negedge PCLK_i);
        #1;
        chk("post done PSEL_o",    32'(PSEL_o),    32'h0);
        chk("post done PRDATA_o",  32'(PRDATA_o),  32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Parameters
REQ-001 SHALL provide parameter ADDR_WIDTH, default 8, width of address ports.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, width of write/read data ports.
REQ-003 SHALL provide parameter PSEL_WIDTH, default 1, number of slave-select lines.
REQ-004 SHALL provide parameter WAIT_TIMEOUT, default 16, maximum ACCESS cycles with PREADY_i low before abort.

Interface
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 PCLK_i  input  1  clock; all state changes on rising edge.
REQ-007 PRESET_i  input  1  asynchronous active-low reset.
REQ-008 PMODE_i  input  2  request: 00 NOP, 10 READ, 11 WRITE, 01 treated as NOP.
REQ-009 PADDR_i  input  ADDR_WIDTH  request address.
REQ-010 PSEL_i  input  PSEL_WIDTH  request slave-select pattern.
REQ-011 PWDATA_i  input  DATA_WIDTH  request write data.
REQ-012 PREADY_i  input  1  slave ready.
REQ-013 PRDATA_i  input  DATA_WIDTH  slave read data.
REQ-014 PWRITE_o  output  1  APB direction (1 write).
REQ-015 PADDR_o  output  ADDR_WIDTH  APB address.
REQ-016 PSEL_o  output  PSEL_WIDTH  APB select.
REQ-017 PENABLE_o  output  1  APB enable.
REQ-018 PWDATA_o  output  DATA_WIDTH  APB write data.
REQ-019 PREADY_o  output  1  transfer-complete strobe to requester.
REQ-020 PRDATA_o  output  DATA_WIDTH  last completed read data.
REQ-021 PSLVERR_o  output  1  timeout error strobe.

Function
REQ-022 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-023 A request SHALL be valid when PMODE_i[1]=1 and PSEL_i is nonzero; otherwise it is a NOP.
REQ-024 IDLE with valid request at a rising edge SHALL capture PADDR_i->PADDR_o, PSEL_i->PSEL_o, PMODE_i[0]->PWRITE_o, PWDATA_i->PWDATA_o (write only; reads keep previous PWDATA_o) and enter SETUP.
REQ-025 SETUP SHALL drive PSEL_o=captured, PENABLE_o=0, and unconditionally enter ACCESS after one cycle.
REQ-026 ACCESS SHALL drive PENABLE_o=1 with PADDR_o, PWRITE_o, PWDATA_o, PSEL_o held stable.
REQ-027 ACCESS with PREADY_i=0 SHALL remain in ACCESS (wait state), outputs unchanged.
REQ-028 ACCESS with PREADY_i=1 SHALL complete the transfer; if a valid request is present it SHALL capture it (per REQ-024) and go directly to SETUP, else go to IDLE.
REQ-029 Back-to-back transfers without wait states SHALL take exactly 2 cycles each (SETUP, ACCESS).
REQ-030 PREADY_o SHALL be combinational: 1 exactly when state=ACCESS and PREADY_i=1.
REQ-031 On completion of a read, PRDATA_o SHALL register PRDATA_i; PRDATA_o SHALL hold otherwise, including across writes.
REQ-032 IDLE SHALL drive PSEL_o=0 and PENABLE_o=0; PADDR_o, PWRITE_o, PWDATA_o hold last values.
REQ-033 A wait counter SHALL count consecutive ACCESS cycles with PREADY_i=0; on reaching WAIT_TIMEOUT, the FSM SHALL abort to IDLE and PSLVERR_o SHALL pulse high for exactly that one cycle (registered, visible the cycle after the timeout edge); counter clears on leaving ACCESS.
REQ-034 Request inputs SHALL be ignored in SETUP and in ACCESS while PREADY_i=0.

Reset
REQ-035 PRESET_i=0 SHALL immediately, regardless of clock, force state IDLE and all outputs to 0 (PWRITE_o, PADDR_o, PSEL_o, PENABLE_o, PWDATA_o, PRDATA_o, PSLVERR_o, PREADY_o), clearing the wait counter.
REQ-036 Reset asserted mid-transfer SHALL abort it with no completion strobe; the first transfer after release starts from IDLE.

Verification
REQ-037 Writes, PREADY_i=1, PSEL_i=1, PMODE_i=11: 0x28@0x15 then 0x72@0x01 held until each is captured -> SETUP/ACCESS pairs every 2 cycles, PENABLE_o toggles 0,1,0,1, PWRITE_o=1, PREADY_o pulses each ACCESS.
REQ-038 Read, PMODE_i=10, PADDR_i=0x20, PRDATA_i=0xA5, PREADY_i=1 -> PWRITE_o=0, PRDATA_o=0xA5 after ACCESS; next write leaves PRDATA_o=0xA5.
REQ-039 Write 0x66@0x02 with PREADY_i low 3 ACCESS cycles -> PENABLE_o high 4 cycles, outputs stable, single PREADY_o pulse.
REQ-040 PREADY_i held 0 -> after 16 ACCESS cycles FSM returns to IDLE, PSEL_o=0, PSLVERR_o one-cycle pulse, no PREADY_o.
REQ-041 PMODE_i=01 or PSEL_i=0 -> stays IDLE, PSEL_o=0; PRESET_i=0 during ACCESS -> all outputs 0 asynchronously.
